// File: rtl/vdp_super_res_writer.sv
// ---------------------------------------------------------------------------
// vdp_super_res_writer
//
// CPU-side write path into the super-res / super-mid framebuffer held in
// 32-bit VRAM.
// - Each CPU byte write is queued at an auto-incrementing 19-bit byte pointer.
// - Queued bytes become byte-masked 32-bit VRAM write requests.
// - A new request only starts while the display fetch is not holding the bus.
// Framebuffer byte n lives at word n>>2, lane n[1:0], bits [8*lane+7:8*lane].
// This matches the layout used by the super-res display reader.
//
// Optional feature (compile-time macro COALESCE_EN):
//   When defined, a GATHER state merges later queued bytes into the staged
//   request. A byte is merged only if it targets the same word and an unused
//   lane. When undefined, every byte becomes its own single-lane request.
//
// Parameters:
//   FIFO_DEPTH         queued byte writes (power of two, >= 2)
//
// Ports:
//   clk                system clock
//   reset_n            asynchronous active-low reset
//   vdp_super          super mode enable; low holds the block in reset state
//   addr_load          pulse: load write pointer from addr_in
//   addr_in[18:0]      byte address
//   wr_strobe          pulse: queue wr_data at the current pointer
//   wr_data[7:0]       byte to write
//   super_res_drawing  display owns the VRAM bus; no new request may start
//   vram_wr_req        write request, held until acknowledged
//   vram_wr_addr[16:0] word address
//   vram_wr_data[31:0] write data, unmasked lanes driven 0
//   vram_wr_mask[3:0]  byte enables, bit i = lane i
//   vram_wr_ack        one-cycle accept from the VRAM arbiter
//   fifo_full          FIFO holds FIFO_DEPTH entries
//   busy               FIFO non-empty or request outstanding
//   overflow           sticky: a write arrived while the FIFO was full
// ---------------------------------------------------------------------------
module vdp_super_res_writer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vdp_super,
  input  logic        addr_load,
  input  logic [18:0] addr_in,
  input  logic        wr_strobe,
  input  logic [7:0]  wr_data,
  input  logic        super_res_drawing,
  output logic        vram_wr_req,
  output logic [16:0] vram_wr_addr,
  output logic [31:0] vram_wr_data,
  output logic [3:0]  vram_wr_mask,
  input  logic        vram_wr_ack,
  output logic        fifo_full,
  output logic        busy,
  output logic        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
`ifdef COALESCE_EN
  localparam logic [1:0] ST_GATHER = 2'd1;
`endif
  localparam logic [1:0] ST_REQ    = 2'd2;

  // One-hot byte enable for a lane
  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    logic [3:0] m;
    m = 4'd0;
    case (lane)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0010;
      2'd2:    m = 4'b0100;
      2'd3:    m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Place a byte on its lane, all other lanes zero
  function automatic logic [31:0] lane_data(input logic [1:0] lane, input logic [7:0] b);
    logic [31:0] d;
    d = 32'd0;
    case (lane)
      2'd0:    d[7:0]   = b;
      2'd1:    d[15:8]  = b;
      2'd2:    d[23:16] = b;
      2'd3:    d[31:24] = b;
      default: d        = 32'd0;
    endcase
    return d;
  endfunction

  // Registers
  logic [18:0]      ptr_r;
  logic [26:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [1:0]       state_r;
  logic             req_r;
  logic [16:0]      addr_r;
  logic [31:0]      data_r;
  logic [3:0]       mask_r;
  logic             full_r;
  logic             busy_r;
  logic             overflow_r;

  // Combinational next-state signals
  logic [26:0]      head_s;
  logic [18:0]      head_addr_s;
  logic [7:0]       head_data_s;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic [18:0]      push_addr_s;
  logic [18:0]      ptr_nxt_s;
  logic             push_s;
  logic             pop_s;
  logic             overflow_set_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [1:0]       state_nxt_s;
  logic             req_nxt_s;
  logic [16:0]      addr_nxt_s;
  logic [31:0]      data_nxt_s;
  logic [3:0]       mask_nxt_s;

  assign head_s       = mem_r[rd_ptr_r];
  assign head_addr_s  = head_s[26:8];
  assign head_data_s  = head_s[7:0];
  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  assign fifo_full_s  = (count_r == CNT_W'(FIFO_DEPTH));

  // Pointer: a same-cycle load redirects the push as well as the pointer
  always_comb begin
    push_addr_s = ptr_r;
    ptr_nxt_s   = ptr_r;
    if (addr_load) begin
      push_addr_s = addr_in;
    end else begin
      push_addr_s = ptr_r;
    end
    if (wr_strobe) begin
      ptr_nxt_s = push_addr_s + 19'd1;
    end else begin
      ptr_nxt_s = push_addr_s;
    end
  end

  // Request state machine and staging register next-state
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    req_nxt_s   = req_r;
    addr_nxt_s  = addr_r;
    data_nxt_s  = data_r;
    mask_nxt_s  = mask_r;
    case (state_r)
      ST_IDLE: begin
        req_nxt_s = 1'b0;
        if (!fifo_empty_s && !super_res_drawing) begin
          pop_s      = 1'b1;
          addr_nxt_s = head_addr_s[18:2];
          data_nxt_s = lane_data(head_addr_s[1:0], head_data_s);
          mask_nxt_s = lane_mask(head_addr_s[1:0]);
`ifdef COALESCE_EN
          state_nxt_s = ST_GATHER;
`else
          state_nxt_s = ST_REQ;
          req_nxt_s   = 1'b1;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
`ifdef COALESCE_EN
      ST_GATHER: begin
        // A lane already set means a later value for the same byte: it must
        // go out as its own request so the last write wins.
        if (!fifo_empty_s && (head_addr_s[18:2] == addr_r) &&
            ((mask_r & lane_mask(head_addr_s[1:0])) == 4'd0)) begin
          pop_s       = 1'b1;
          data_nxt_s  = data_r | lane_data(head_addr_s[1:0], head_data_s);
          mask_nxt_s  = mask_r | lane_mask(head_addr_s[1:0]);
          state_nxt_s = ST_GATHER;
        end else begin
          state_nxt_s = ST_REQ;
          req_nxt_s   = 1'b1;
        end
      end
`endif
      ST_REQ: begin
        // Drawing going high here does not withdraw the request
        if (vram_wr_ack) begin
          req_nxt_s   = 1'b0;
          state_nxt_s = ST_IDLE;
        end else begin
          req_nxt_s   = 1'b1;
          state_nxt_s = ST_REQ;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        req_nxt_s   = 1'b0;
      end
    endcase
  end

  // FIFO push/pop decision and occupancy next-state
  always_comb begin
    push_s         = wr_strobe && (!fifo_full_s || pop_s);
    overflow_set_s = wr_strobe && fifo_full_s && !pop_s;
    count_nxt_s    = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (vdp_super && push_s) begin
      mem_r[wr_ptr_r] <= {push_addr_s, wr_data};
    end
  end

  // Control, staging and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r      <= 19'd0;
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      state_r    <= ST_IDLE;
      req_r      <= 1'b0;
      addr_r     <= 17'd0;
      data_r     <= 32'd0;
      mask_r     <= 4'd0;
      full_r     <= 1'b0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else if (!vdp_super) begin
      ptr_r      <= 19'd0;
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      state_r    <= ST_IDLE;
      req_r      <= 1'b0;
      addr_r     <= 17'd0;
      data_r     <= 32'd0;
      mask_r     <= 4'd0;
      full_r     <= 1'b0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      ptr_r      <= ptr_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r    <= count_nxt_s;
      state_r    <= state_nxt_s;
      req_r      <= req_nxt_s;
      addr_r     <= addr_nxt_s;
      data_r     <= data_nxt_s;
      mask_r     <= mask_nxt_s;
      full_r     <= (count_nxt_s == CNT_W'(FIFO_DEPTH));
      busy_r     <= (count_nxt_s != {CNT_W{1'b0}}) || (state_nxt_s != ST_IDLE);
      overflow_r <= overflow_r || overflow_set_s;
    end
  end

  assign vram_wr_req  = req_r;
  assign vram_wr_addr = addr_r;
  assign vram_wr_data = data_r;
  assign vram_wr_mask = mask_r;
  assign fifo_full    = full_r;
  assign busy         = busy_r;
  assign overflow     = overflow_r;

endmodule
